// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// The buffer entry is sized for the widest supported datapath.
package wb_port_arbiter_pkg;

    localparam int WB_XLEN          = 64;
    localparam int DEFAULT_DEPTH    = 2;
    localparam int DEFAULT_MAX_WAIT = 4;

    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_MD   = 1'b1;

    typedef struct packed {
        logic               valid;
        logic [4:0]         dst;
        logic [WB_XLEN-1:0] data;
    } wb_arb_entry_t;

    function automatic logic [31:0] dstOneHot(input logic [4:0] dst);
        return 32'd1 << dst;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Ordered mul/div result buffer with per-entry kill-by-destination
// and a pending-destination mask built from the stored valid bits.
module wb_arb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int XLEN  = WB_XLEN
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            push,
    input  logic [4:0]      pushDst,
    input  logic [XLEN-1:0] pushData,
    input  logic            pop,
    input  logic            killEn,
    input  logic [4:0]      killDst,
    output logic            headOcc,
    output logic            headValid,
    output logic [4:0]      headDst,
    output logic [XLEN-1:0] headData,
    output logic            full,
    output logic [31:0]     pendMask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;
    wb_arb_entry_t entryView [DEPTH];
    wb_arb_entry_t headEntry;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gEntry
            wb_arb_entry_t entryReg;
            logic wrHit;
            logic popHit;
            logic killHit;

            assign wrHit   = push && (tailPtr == PW'(gi));
            assign popHit  = pop && (headPtr == PW'(gi));
            assign killHit = killEn && entryReg.valid && (entryReg.dst == killDst);

            // A fresh write takes precedence, so a same-cycle push is never killed.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    entryReg <= '0;
                end else if (wrHit) begin
                    entryReg <= '{valid: (pushDst != 5'd0), dst: pushDst, data: WB_XLEN'(pushData)};
                end else if (popHit || killHit) begin
                    entryReg.valid <= 1'b0;
                end
            end

            assign entryView[gi] = entryReg;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + PW'(1);
            if (pop)  headPtr <= headPtr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    assign headEntry = entryView[headPtr];
    assign headOcc   = (count != '0);
    assign headValid = headOcc && headEntry.valid;
    assign headDst   = headEntry.dst;
    assign headData  = headEntry.data[XLEN-1:0];
    assign full      = (count == CW'(DEPTH));

    // Popped and empty slots always carry valid=0, so no occupancy test is needed.
    always_comb begin
        pendMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryView[i].valid) pendMask = pendMask | dstOneHot(entryView[i].dst);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between writeback (priority) and buffered
// mul/div results, forcing a stall slot when the buffer head starves.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int XLEN     = WB_XLEN
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pipe_valid,
    input  logic            pipe_regwrite,
    input  logic [4:0]      pipe_dst,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [4:0]      md_dst,
    input  logic [XLEN-1:0] md_data,
    output logic            rf_wen,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            rf_src,
    output logic            stall_pipe,
    output logic [31:0]     pend_mask
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0]   waitCnt;
    logic            headOcc;
    logic            headValid;
    logic [4:0]      headDst;
    logic [XLEN-1:0] headData;
    logic            bufFull;
    logic            pipeReq;
    logic            grantPipe;
    logic            grantMd;
    logic            popHead;
    logic            pushMd;

    assign pipeReq    = pipe_valid && pipe_regwrite && (pipe_dst != 5'd0);
    assign stall_pipe = (waitCnt == WW'(MAX_WAIT)) && headValid;
    assign grantMd    = stall_pipe || (!pipeReq && headValid);
    assign grantPipe  = !stall_pipe && pipeReq;
    // Killed or x0 heads leave without a port slot.
    assign popHead    = headOcc && (grantMd || !headValid);
    assign md_ready   = !bufFull;
    assign pushMd     = md_valid && !bufFull;

    wb_arb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (pushMd),
        .pushDst   (md_dst),
        .pushData  (md_data),
        .pop       (popHead),
        .killEn    (grantPipe),
        .killDst   (pipe_dst),
        .headOcc   (headOcc),
        .headValid (headValid),
        .headDst   (headDst),
        .headData  (headData),
        .full      (bufFull),
        .pendMask  (pend_mask)
    );

    always_comb begin
        rf_wen = grantPipe || grantMd;
        rf_wa  = '0;
        rf_wd  = '0;
        rf_src = SRC_PIPE;
        if (grantPipe) begin
            rf_wa = pipe_dst;
            rf_wd = pipe_wdata;
        end else if (grantMd) begin
            rf_wa  = headDst;
            rf_wd  = headData;
            rf_src = SRC_MD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            waitCnt <= '0;
        end else if (!headOcc || popHead) begin
            waitCnt <= '0;
        end else if (headValid && !grantMd && (waitCnt != WW'(MAX_WAIT))) begin
            waitCnt <= waitCnt + WW'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's
// port outputs; a negedge monitor compares them against the DUT.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int XLEN     = 64;

    logic            clk;
    logic            resetn;
    logic            pipe_valid;
    logic            pipe_regwrite;
    logic [4:0]      pipe_dst;
    logic [XLEN-1:0] pipe_wdata;
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_dst;
    logic [XLEN-1:0] md_data;
    logic            rf_wen;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            rf_src;
    logic            stall_pipe;
    logic [31:0]     pend_mask;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pipe_valid    (pipe_valid),
        .pipe_regwrite (pipe_regwrite),
        .pipe_dst      (pipe_dst),
        .pipe_wdata    (pipe_wdata),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_dst        (md_dst),
        .md_data       (md_data),
        .rf_wen        (rf_wen),
        .rf_wa         (rf_wa),
        .rf_wd         (rf_wd),
        .rf_src        (rf_src),
        .stall_pipe    (stall_pipe),
        .pend_mask     (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [4:0]  dst;
        logic [63:0] data;
    } ment_t;

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        src;
        logic        stall;
        logic        ready;
        logic [31:0] pend;
    } exp_t;

    ment_t mq[$];
    exp_t  expQ[$];
    int    mWait;
    bit    lastStall;
    int    total;
    int    bad;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    task automatic resetModel();
        mq.delete();
        expQ.delete();
        mWait     = 0;
        lastStall = 0;
    endtask

    // Drives one cycle, predicts its outputs, then advances the model past the edge.
    task automatic cycle(input bit pv, input bit prw, input logic [4:0] pd, input logic [63:0] pw,
                         input bit mv, input logic [4:0] md, input logic [63:0] mdat, output bit acc);
        bit          hv, stl, preq, gm, gp, rdy, popped, wasEmpty;
        exp_t        e;
        logic [31:0] pend;
        @(posedge clk);
        #1;
        pipe_valid    = pv;
        pipe_regwrite = prw;
        pipe_dst      = pd;
        pipe_wdata    = pw;
        md_valid      = mv;
        md_dst        = md;
        md_data       = mdat;

        wasEmpty = (mq.size() == 0);
        hv   = !wasEmpty && mq[0].v;
        stl  = (mWait == MAX_WAIT) && hv;
        preq = pv && prw && (pd != 5'd0);
        gm   = stl || (!preq && hv);
        gp   = !stl && preq;
        rdy  = (mq.size() < DEPTH);
        pend = '0;
        foreach (mq[i]) if (mq[i].v) pend[mq[i].dst] = 1'b1;

        e.wen   = gp || gm;
        e.wa    = gp ? pd : (gm ? mq[0].dst : 5'd0);
        e.wd    = gp ? pw : (gm ? mq[0].data : 64'd0);
        e.src   = gm;
        e.stall = stl;
        e.ready = rdy;
        e.pend  = pend;
        expQ.push_back(e);

        acc    = mv && rdy;
        popped = 0;
        if (!wasEmpty && (gm || !mq[0].v)) begin
            void'(mq.pop_front());
            popped = 1;
        end
        if (gp) foreach (mq[i]) if (mq[i].dst == pd) mq[i].v = 0;
        if (acc) mq.push_back('{v: (md != 5'd0), dst: md, data: mdat});
        if (wasEmpty || popped) mWait = 0;
        else if (hv && !gm) mWait = (mWait < MAX_WAIT) ? mWait + 1 : MAX_WAIT;
        lastStall = stl;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                if (rf_wen) $display("write src=%0d x%0d <= %h", rf_src, rf_wa, rf_wd);
                chk("rf_wen", rf_wen, e.wen);
                chk("rf_wa", rf_wa, e.wa);
                chk("rf_wd", rf_wd, e.wd);
                chk("rf_src", rf_src, e.src);
                chk("stall_pipe", stall_pipe, e.stall);
                chk("md_ready", md_ready, e.ready);
                chk("pend_mask", pend_mask, e.pend);
            end
        end
    end

    initial begin
        bit          acc;
        bit          rpv, rprw, rmv, mdPend;
        logic [4:0]  rpd, rmd;
        logic [63:0] rpw, rmdat;

        total = 0;
        bad   = 0;
        resetModel();
        resetn        = 1'b0;
        pipe_valid    = 1'b0;
        pipe_regwrite = 1'b0;
        pipe_dst      = '0;
        pipe_wdata    = '0;
        md_valid      = 1'b0;
        md_dst        = '0;
        md_data       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rf_wen", rf_wen, 0);
        chk("reset_md_ready", md_ready, 1);
        chk("reset_pend_mask", pend_mask, 0);
        chk("reset_stall", stall_pipe, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Single push is written the next cycle; async reset mid-drain clears outputs.
        cycle(0, 0, 0, 0, 1, 5, 64'hAB, acc);
        @(posedge clk);
        #1;
        md_valid = 1'b0;
        #1;
        chk("drain_wen", rf_wen, 1);
        chk("drain_wa", rf_wa, 5);
        chk("drain_wd", rf_wd, 64'hAB);
        chk("drain_src", rf_src, 1);
        chk("drain_pend", pend_mask, 32'h20);
        #1;
        resetn = 1'b0;
        #1;
        chk("midreset_wen", rf_wen, 0);
        chk("midreset_pend", pend_mask, 0);
        chk("midreset_ready", md_ready, 1);
        chk("midreset_stall", stall_pipe, 0);
        resetModel();
        @(negedge clk);
        resetn = 1'b1;

        // Starvation: continuous pipe writes, forced slot after MAX_WAIT cycles.
        cycle(1, 1, 3, 64'h33, 1, 7, 64'h11, acc);
        for (int k = 0; k < 5; k++) cycle(1, 1, 3, 64'h33, 0, 0, 0, acc);
        #1;
        chk("starve_stall", stall_pipe, 1);
        chk("starve_wa", rf_wa, 7);
        chk("starve_src", rf_src, 1);
        for (int k = 0; k < 3; k++) cycle(1, 1, 3, 64'h33, 0, 0, 0, acc);

        // Fill the buffer, then hold a third result until space opens.
        cycle(1, 1, 20, 64'h20, 1, 1, 64'h101, acc);
        cycle(1, 1, 20, 64'h20, 1, 2, 64'h102, acc);
        acc = 0;
        for (int k = 0; k < 12 && !acc; k++) begin
            cycle(1, 1, 20, 64'h20, 1, 3, 64'h103, acc);
            if (k == 0) begin
                #1;
                chk("full_ready", md_ready, 0);
            end
        end
        chk("full_accept", acc, 1);
        for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 0, 0, 0, acc);

        // Younger pipe write to the same register kills the buffered result.
        cycle(1, 1, 20, 64'h20, 1, 9, 64'h1, acc);
        cycle(1, 1, 9, 64'h2, 0, 0, 0, acc);
        #1;
        chk("kill_wa", rf_wa, 9);
        chk("kill_wd", rf_wd, 64'h2);
        cycle(0, 0, 0, 0, 0, 0, 0, acc);
        #1;
        chk("kill_noport", rf_wen, 0);
        chk("kill_pend", pend_mask, 0);

        // Pipe write to x0 leaves the port to the buffer head.
        cycle(1, 1, 20, 64'h20, 1, 4, 64'h5, acc);
        cycle(1, 1, 0, 64'h99, 0, 0, 0, acc);
        #1;
        chk("x0_wen", rf_wen, 1);
        chk("x0_wa", rf_wa, 4);
        chk("x0_wd", rf_wd, 64'h5);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0, 0, acc);

        // Random traffic with upstream holding on stall and md holding until accepted.
        mdPend = 0;
        rpv = 0; rprw = 0; rpd = 0; rpw = 0; rmv = 0; rmd = 0; rmdat = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!lastStall) begin
                rpv  = ($urandom_range(0, 99) < 75);
                rprw = ($urandom_range(0, 99) < 85);
                rpd  = 5'($urandom_range(0, 7));
                rpw  = {$urandom, $urandom};
            end
            if (!mdPend) begin
                rmv   = ($urandom_range(0, 99) < 40);
                rmd   = 5'($urandom_range(0, 7));
                rmdat = {$urandom, $urandom};
            end
            cycle(rpv, rprw, rpd, rpw, rmv, rmd, rmdat, acc);
            mdPend = rmv && !acc;
        end
        for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0, 0, 0, 0, acc);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between the in-order pipeline writeback stage and the multi-cycle mul/div unit.
- Pipeline writes get priority. Mul/div results wait in a small ordered buffer and drain on idle port cycles.
- A starvation counter forces a pipeline stall slot so a waiting result cannot wait forever.
- Exports a pending-destination mask to the hazard unit.
- Sits between writeback and the regfile write port.

Parameters:
- DEPTH, 2, mul/div result buffer entries (power of 2, ≥2).
- MAX_WAIT, 4, cycles the buffer head may wait before a forced slot.
- XLEN, 64, data width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pipe_valid  in  1  writeback stage holds a valid retiring instruction
- pipe_regwrite  in  1  that instruction writes a register
- pipe_dst  in  5  destination register
- pipe_wdata  in  XLEN  write data
- md_valid  in  1  mul/div result offered
- md_ready  out  1  buffer can accept (= !full)
- md_dst  in  5  mul/div destination
- md_data  in  XLEN  mul/div result
- rf_wen  out  1  regfile write enable
- rf_wa  out  5  regfile write address
- rf_wd  out  XLEN  regfile write data
- rf_src  out  1  0 = pipeline, 1 = mul/div buffer
- stall_pipe  out  1  upstream must hold writeback this cycle
- pend_mask  out  32  bit r set while a valid buffered entry targets r

Behaviour:
- Reset (resetn=0, async): buffer empty, all entry valids 0, wait counter 0. Outputs: rf_wen=0, stall_pipe=0, pend_mask=0, md_ready=1.
- Pipe request: pipe_req = pipe_valid & pipe_regwrite & pipe_dst!=0. Writes to x0 are dropped and never use the port.
- Mul/div accept: md_valid & md_ready pushes {1, md_dst, md_data} at the clock edge. md_dst==0 is accepted and stored invalid (no write).
- No push-through. The earliest regfile write of an accepted result is the next cycle.
- md_ready = !full. A push is not allowed into the slot freed by a same-cycle pop.
- Arbitration (combinational, single cycle):
  - If stall_pipe=1: grant the buffer head. pipe_* are ignored; upstream holds them and retires them the next cycle.
  - Else if pipe_req: grant pipe.
  - Else if the head is valid: grant the head.
  - Else: rf_wen=0.
- Port outputs: rf_wa/rf_wd/rf_src follow the granted source. rf_wen=1 only on a grant. With no grant, rf_wa/rf_wd=0 and rf_src=0.
- Invalid head (killed, or x0): popped at the clock edge without using the port. In that cycle the port is free for pipe.
- Kill rule: when pipe is granted with dst d, every buffered entry with dst d has its valid cleared at that edge (pipe is younger). An entry pushed in the same cycle is not killed. The hazard unit forbids that case.
- Wait counter:
  - Increments each cycle a valid head exists and is not granted.
  - Clears on head pop or when the buffer is empty.
  - Saturates at MAX_WAIT.
  - stall_pipe = (counter==MAX_WAIT) & head valid; registered state, combinational output.
  - A forced grant pops the head, so the counter returns to 0.
- pend_mask: OR of one-hot(dst) over valid entries; excludes the entry granted this cycle? No: it reflects state registers only (includes the head until it pops).
- Pointers are DEPTH-modulo with a count register. Full = count==DEPTH, empty = count==0.
- Push while full cannot occur (md_ready=0). Pop while empty cannot occur.

Decomposition:
- Shared package entries: typedef wb_arb_entry_t {valid, dst[4:0], data[XLEN-1:0]}, the rf_src encoding constants (SRC_PIPE=0, SRC_MD=1), and the default MAX_WAIT/DEPTH.
- One sub-module, wb_arb_fifo:
  - Holds the ordered buffer with head/tail/count.
  - Provides a per-entry kill-by-dst input and the pend_mask reduction.
- The top level holds arbitration and the wait counter.

Test Plan:
- Reset then idle → rf_wen=0, md_ready=1, pend_mask=0, stall_pipe=0; assert resetn low mid-drain with 1 entry → outputs return to reset values immediately.
- md push {x5, 0xAB} at cycle T, pipe idle → rf_wen=1, rf_wa=5, rf_wd=0xAB, rf_src=1 at T+1; pend_mask[5]=1 only during T+1.
- Pipe writes x3 every cycle; one md entry {x7, 0x11} pushed, MAX_WAIT=4 → 4 pipe grants, then stall_pipe=1 with an x7 write (rf_src=1), then the pipe resumes.
- Two md pushes fill DEPTH=2 → md_ready=0; a third md_valid is held and accepted the cycle after the first pop.
- Buffer holds {x9, 0x1}; pipe writes x9=0x2 → the regfile sees only x9=0x2; the entry is dropped next cycle with no port use; pend_mask[9] clears.
- Pipe dst=0 with pipe_regwrite=1 and a valid head {x4, 0x5} → head granted the same cycle, rf_wa=4.
